muldiv_unit: RTL

- Multi-cycle iterative multiply/divide unit with architectural HI/LO registers.
- Successor to the datapath's single-cycle combinational multiplier and HI/LO load registers.
- Adds signed and unsigned multiply, signed and unsigned divide, a start/busy/done handshake and direct HI/LO writes (MTHI/MTLO).
- Sits beside the ALU. The controller stalls the PC while busy=1, and MFHI/MFLO read hi/lo through the existing result mux.

---
 rtl/mips_pkg.sv | 17 +
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants.
// Multiply/divide op encodings (also used by the aludec funct decode) and the
// state encoding of the iterative multiply/divide unit.
package mips_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One iteration per clock: shift-add multiply or restoring divide on a shared
// 2*WIDTH accumulator, followed by one sign-correction cycle.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, op, a, b   launch (accepted only while idle); op = MULTU/MULT/DIVU/DIV
//   hi_we, lo_we      MTHI/MTLO strobes with wdata (accepted only while idle)
//   busy              operation in flight (combinational from state)
//   done              one-cycle pulse once hi/lo hold the new result
//   hi, lo            HI/LO registers
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // acc: mul = {partial product hi, remaining multiplier}; div = {remainder, quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;     // |multiplicand| or |divisor|
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;     // negate product / quotient
  logic               rneg_q, rneg_d;   // negate remainder
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               sgn;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     add_x, add_y;
  logic [WIDTH+1:0]   add_full;

  // Shared adder: mul adds the multiplicand into the upper half; div subtracts
  // the divisor from the shifted remainder. The extra top bit is the carry out,
  // i.e. "shifted remainder >= divisor", which stays correct even for a zero
  // divisor where the shifted remainder can exceed WIDTH bits.
  always_comb begin
    add_x    = is_div_q ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    add_y    = is_div_q ? ~{1'b0, opb_q} : (acc_q[0] ? {1'b0, opb_q} : '0);
    add_full = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+2)'(is_div_q);
  end

  always_comb begin
    sgn   = op[0];
    a_abs = (sgn && a[WIDTH-1]) ? -a : a;
    b_abs = (sgn && b[WIDTH-1]) ? -b : b;

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          // a sits in the low half in both modes: multiplier bits shift out
          // to the right, dividend bits shift out to the left.
          acc_d    = {{WIDTH{1'b0}}, a_abs};
          opb_d    = b_abs;
          is_div_d = op[1];
          neg_d    = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d   = sgn && op[1] && a[WIDTH-1];
          bzero_d  = (b == '0);
          cnt_d    = '0;
          state_d  = MD_RUN;
        end
      end
      MD_RUN: begin
        if (is_div_q) begin
          if (add_full[WIDTH+1])
            acc_d = {add_full[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {add_full[WIDTH:0], acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = MD_FIX;
      end
      MD_FIX: begin
        if (is_div_q) begin
          lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
          hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          // Zero divisor: remainder already equals a after sign fix; quotient forced.
          if (bzero_q) lo_d = '1;
        end else begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != MD_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
